dad_mcp_seq: RTL
================

DAD_MCP_SEQ -- requirements
Module: dad_mcp_seq

Interface
REQ-001 Parameter SETUP_CYC, default 4: cycles ADDR/SEL/MODE are stable before the strobe rises.
REQ-002 Parameter STROBE_CYC, default 8: DAD_STROBE high width in cycles.
REQ-003 Parameter HOLD_CYC, default 4: cycles ADDR/SEL/MODE are held after the strobe falls.
REQ-004 Parameter PWRUP_CYC, default 1024: cycles DAD_RESETN is held low after reset.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk_200m  in  1  sole clock; every flop is rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  permits start to be accepted.
REQ-009 start  in  1  single-cycle request for one mirror-clock-pulse sequence.
REQ-010 blk_mask  in  16  reset blocks to pulse; bit i selects block i.
REQ-011 sel_cfg  in  2  DAD_SEL value for the sequence.
REQ-012 mode_cfg  in  2  DAD_MODE value for the sequence.
REQ-013 busy  out  1  high from the cycle after start is accepted until done.
REQ-014 done  out  1  one-cycle pulse when a sequence completes.
REQ-015 err_overrun  out  1  one-cycle pulse when start is rejected.
REQ-016 DAD_ADDR  out  4  reset-block address.
REQ-017 DAD_SEL, DAD_MODE  out  2 each  reset-driver select and mode.
REQ-018 DAD_STROBE  out  1  latches the driver command.
REQ-019 DAD_OEZ  out  1  driver output enable, active-low.
REQ-020 DAD_RESETN  out  1  driver reset, active-low.
REQ-021 DAD_SCPENZ  out  1  SCP chip enable; constant 1.

Function
REQ-022 States SHALL be PWRUP, IDLE, SETUP, STROBE, HOLD and DONE.
REQ-023 PWRUP SHALL hold DAD_RESETN=0 and DAD_OEZ=1 for PWRUP_CYC cycles, then go to IDLE with DAD_RESETN=1 and DAD_OEZ=0.
REQ-024 In IDLE, start=1 with enable=1 SHALL do all of the following:
  - latch blk_mask, sel_cfg and mode_cfg;
  - go to SETUP, or to DONE if the latched mask is zero.
REQ-025 start seen in any state other than IDLE, or with enable=0, SHALL be ignored and SHALL pulse err_overrun in the next cycle.
REQ-026 The current block SHALL be the lowest set bit of the latched mask, found by a combinational priority encoder; DAD_ADDR SHALL take its index from the first SETUP cycle.
REQ-027 Per-block timing:
  - SETUP lasts SETUP_CYC cycles;
  - STROBE lasts STROBE_CYC cycles with DAD_STROBE=1;
  - HOLD lasts HOLD_CYC cycles.
REQ-028 On the last HOLD cycle the serviced mask bit SHALL clear; the next state SHALL be SETUP if any bit remains, else DONE.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE; busy SHALL be 0 in IDLE and PWRUP.
REQ-030 For N selected blocks, done SHALL be high exactly N*(SETUP_CYC+STROBE_CYC+HOLD_CYC)+1 cycles after the start cycle; with N=0 it SHALL be high 1 cycle after.
REQ-031 DAD_ADDR, DAD_SEL and DAD_MODE SHALL NOT change while DAD_STROBE=1.
REQ-032 Block order SHALL be ascending index; block 15 SHALL terminate the scan with no wrap-around.
REQ-033 Deasserting enable mid-sequence SHALL NOT abort; the sequence completes normally.
REQ-034 Phase counters SHALL be wide enough for the largest parameter; a parameter value of 0 SHALL be treated as 1.

Reset
REQ-035 During reset the outputs SHALL be:
  - DAD_STROBE=0, DAD_RESETN=0, DAD_OEZ=1, DAD_SCPENZ=1;
  - DAD_ADDR=0, DAD_SEL=0, DAD_MODE=0;
  - busy=0, done=0, err_overrun=0.
  The state SHALL be PWRUP and the latched mask 0.
REQ-036 Reset mid-sequence SHALL force DAD_STROBE=0 in the cycle after reset is sampled, with no done pulse.

Structure
REQ-037 Package dad_pkg SHALL hold the state enum, the default timing constants and the 4-bit block-address type.
REQ-038 Sub-module dad_prio_enc16 SHALL map a 16-bit mask to a 4-bit lowest-set index plus a valid flag.

Verification (defaults: 16 cycles per block)
REQ-039 Release reset -> DAD_RESETN=0 for 1024 cycles, then DAD_RESETN=1 and DAD_OEZ=0; start ignored in PWRUP and err_overrun pulses.
REQ-040 start with blk_mask=16'h0001 -> one strobe at ADDR=0, DAD_STROBE high for 8 cycles; done 17 cycles after start.
REQ-041 blk_mask=16'h8421 -> strobes at ADDR 0, 5, 10, 15 in order; done 65 cycles after start; ADDR stable around every strobe.
REQ-042 blk_mask=0 -> no strobe; done 1 cycle after start.
REQ-043 Second start during busy -> err_overrun pulse and the sequence unaffected; enable dropped mid-sequence -> sequence still completes.
REQ-044 Reset asserted during STROBE -> DAD_STROBE=0 the next cycle, no done, PWRUP re-entered.

Source files
------------

// File: rtl/dad_pkg.sv
// dad_pkg: shared types and constants for the DAD mirror-clock-pulse sequencer.
//   dad_state_e  - sequencer FSM states
//   blk_addr_t   - 4-bit reset-block address
//   DEF_*_CYC    - default phase lengths in clk_200m cycles
//   eff_cyc      - maps a phase length of 0 to 1 (a phase always lasts >= 1 cycle)
//   max_int      - helper for sizing the shared phase counter
package dad_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } dad_state_e;

  typedef logic [3:0] blk_addr_t;

  localparam int DEF_SETUP_CYC  = 4;
  localparam int DEF_STROBE_CYC = 8;
  localparam int DEF_HOLD_CYC   = 4;
  localparam int DEF_PWRUP_CYC  = 1024;

  function automatic int eff_cyc(input int c);
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dad_prio_enc16.sv
// dad_prio_enc16: combinational lowest-set-bit priority encoder.
//   mask_i  [15:0] in   candidate block mask
//   idx_o   [3:0]  out  index of the lowest set bit (0 when mask_i is zero)
//   valid_o        out  1 when any bit of mask_i is set
module dad_prio_enc16
  import dad_pkg::*;
(
  input  logic [15:0] mask_i,
  output blk_addr_t   idx_o,
  output logic        valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |mask_i;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = blk_addr_t'(i);
      end
    end
  end

endmodule

// File: rtl/dad_mcp_seq.sv
// dad_mcp_seq: sequencer that pulses the DAD reset-driver strobe once per
// selected reset block, in ascending block order, after a power-up delay.
//   clk_200m     in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   permits start to be accepted
//   start        in   one-cycle sequence request
//   blk_mask     in   [15:0] blocks to pulse
//   sel_cfg      in   [1:0] DAD_SEL value for the sequence
//   mode_cfg     in   [1:0] DAD_MODE value for the sequence
//   busy         out  sequence in progress (SETUP/STROBE/HOLD/DONE)
//   done         out  one-cycle completion pulse
//   err_overrun  out  one-cycle pulse after a rejected start
//   DAD_ADDR     out  [3:0] reset-block address
//   DAD_SEL      out  [1:0] driver select
//   DAD_MODE     out  [1:0] driver mode
//   DAD_STROBE   out  driver command strobe
//   DAD_OEZ      out  driver output enable, active low
//   DAD_RESETN   out  driver reset, active low
//   DAD_SCPENZ   out  SCP chip enable, tied high
module dad_mcp_seq
  import dad_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int PWRUP_CYC  = DEF_PWRUP_CYC
)(
  input  logic        clk_200m,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] blk_mask,
  input  logic [1:0]  sel_cfg,
  input  logic [1:0]  mode_cfg,
  output logic        busy,
  output logic        done,
  output logic        err_overrun,
  output logic [3:0]  DAD_ADDR,
  output logic [1:0]  DAD_SEL,
  output logic [1:0]  DAD_MODE,
  output logic        DAD_STROBE,
  output logic        DAD_OEZ,
  output logic        DAD_RESETN,
  output logic        DAD_SCPENZ
);

  localparam int SETUP_N  = eff_cyc(SETUP_CYC);
  localparam int STROBE_N = eff_cyc(STROBE_CYC);
  localparam int HOLD_N   = eff_cyc(HOLD_CYC);
  localparam int PWRUP_N  = eff_cyc(PWRUP_CYC);
  localparam int MAX_N    = max_int(max_int(SETUP_N, STROBE_N), max_int(HOLD_N, PWRUP_N));
  // One counter serves every phase; it only ever counts 0 .. MAX_N-1.
  localparam int CNT_W    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_N - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_N - 1);

  dad_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      mask_q, mask_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       mode_q, mode_d;
  blk_addr_t        addr_q, addr_d;
  logic             err_q, err_d;

  blk_addr_t        cur_idx, nxt_idx;
  logic             cur_vld, nxt_vld;
  logic             accept;

  assign accept = start && enable && (state_q == ST_IDLE);

  // Block being serviced now, used to clear its bit at the end of HOLD.
  dad_prio_enc16 u_enc_cur (
    .mask_i  (mask_q),
    .idx_o   (cur_idx),
    .valid_o (cur_vld)
  );

  // Block that will be serviced next; lets DAD_ADDR be registered so it is
  // already correct in the first SETUP cycle.
  dad_prio_enc16 u_enc_nxt (
    .mask_i  (mask_d),
    .idx_o   (nxt_idx),
    .valid_o (nxt_vld)
  );

  // Latched sequence configuration.  Kept apart from the state logic so the
  // mask -> encoder -> state path has no block-level feedback.
  always_comb begin
    mask_d = mask_q;
    sel_d  = sel_q;
    mode_d = mode_q;
    if (accept) begin
      mask_d = blk_mask;
      sel_d  = sel_cfg;
      mode_d = mode_cfg;
    end else if (state_q == ST_HOLD && cnt_q == HOLD_LAST && cur_vld) begin
      mask_d = mask_q & ~(16'd1 << cur_idx);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = start && !accept;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = nxt_vld ? ST_SETUP : ST_DONE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = nxt_vld ? ST_SETUP : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase
    if (state_d == ST_SETUP && state_q != ST_SETUP) begin
      addr_d = nxt_idx;
    end
  end

  always_ff @(posedge clk_200m) begin
    if (reset) begin
      state_q <= ST_PWRUP;
      cnt_q   <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                       (state_q == ST_HOLD)  || (state_q == ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign err_overrun = err_q;
  assign DAD_ADDR    = addr_q;
  assign DAD_SEL     = sel_q;
  assign DAD_MODE    = mode_q;
  assign DAD_STROBE  = (state_q == ST_STROBE);
  assign DAD_OEZ     = (state_q == ST_PWRUP);
  assign DAD_RESETN  = (state_q != ST_PWRUP);
  assign DAD_SCPENZ  = 1'b1;

endmodule
